// File: rtl/zoom_controller.sv
// Zoom/pan view controller: button edges queue one op, CALC updates the view, then a frame is requested.
// Optional render watchdog is enabled with ZOOM_WATCHDOG_EN.
module zoom_controller #(
  parameter int          COORD_W  = 32,
  parameter int          SCREEN_W = 800,
  parameter int          SCREEN_H = 600,
  parameter int          MAX_ZOOM = 16,
  parameter int unsigned TIMEOUT  = 24'hFFFFFF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               zoom_in_btn,
  input  logic               zoom_out_btn,
  input  logic               home_btn,
  input  logic [25:0]        sprite_x,
  input  logic [25:0]        sprite_y,
  input  logic               render_ready,
  input  logic               render_done,
  output logic               render_start,
  output logic [COORD_W-1:0] view_cx,
  output logic [COORD_W-1:0] view_cy,
  output logic [4:0]         view_shift,
  output logic               busy,
  output logic               timeout_err
);

  // Handshake: render_start is held while in REQ and only drops on the cycle render_ready is also high.
  typedef enum logic [1:0] {IDLE, CALC, REQ, WAIT} state_t;
  typedef enum logic [1:0] {OP_HOME, OP_IN, OP_OUT} op_t;

  localparam int EW = COORD_W + 32;
  localparam logic signed [EW-1:0] CMAX = (EW'(1) << (COORD_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] CMIN = ~CMAX;
  localparam logic [COORD_W-1:0] HOME_CX = -(COORD_W'(1) << (COORD_W - 5));

  state_t state, state_next;
  op_t    slot_op, ev_op;
  logic   slot_full, ev_any;
  logic   home_q, in_q, out_q;
  logic   ev_home, ev_in, ev_out;
  logic   wd_expire;

  assign ev_home = home_btn & ~home_q;
  assign ev_in   = zoom_in_btn & ~in_q;
  assign ev_out  = zoom_out_btn & ~out_q;
  assign ev_any  = ev_home | ev_in | ev_out;

  always_comb begin
    ev_op = OP_OUT;
    if (ev_home)    ev_op = OP_HOME;
    else if (ev_in) ev_op = OP_IN;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      home_q <= 1'b0;
      in_q   <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      home_q <= home_btn;
      in_q   <= zoom_in_btn;
      out_q  <= zoom_out_btn;
    end
  end

  // CALC empties the slot, so an edge on that same cycle refills it instead of being dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slot_full <= 1'b0;
      slot_op   <= OP_HOME;
    end else if (state == CALC) begin
      slot_full <= ev_any;
      slot_op   <= ev_op;
    end else if (!slot_full && ev_any) begin
      slot_full <= 1'b1;
      slot_op   <= ev_op;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= REQ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (slot_full) state_next = CALC;
      CALC:    state_next = REQ;
      REQ:     if (render_ready) state_next = WAIT;
      WAIT:    if (render_done || wd_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    render_start = (state == REQ);
    busy         = (state != IDLE);
  end

`ifdef ZOOM_WATCHDOG_EN
  logic [23:0] wd_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)              wd_cnt <= '0;
    else if (state != WAIT) wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + 24'd1;
  end

  assign wd_expire   = (state == WAIT) && !render_done && (wd_cnt == 24'(TIMEOUT - 1));
  assign timeout_err = wd_expire;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  logic [25:0]          sx_c, sy_c;
  logic signed [31:0]   px, py;
  logic [4:0]           sh_amt;
  logic signed [EW-1:0] cx_sum, cy_sum;

  // Offsets are scaled by the pre-update shift and summed wide so saturation can be detected.
  always_comb begin
    sx_c   = (sprite_x > 26'(SCREEN_W - 16)) ? 26'(SCREEN_W - 16) : sprite_x;
    sy_c   = (sprite_y > 26'(SCREEN_H - 16)) ? 26'(SCREEN_H - 16) : sprite_y;
    px     = $signed({6'd0, sx_c}) + 32'(8 - SCREEN_W / 2);
    py     = $signed({6'd0, sy_c}) + 32'(8 - SCREEN_H / 2);
    sh_amt = 5'd20 - view_shift;
    cx_sum = $signed({{32{view_cx[COORD_W-1]}}, view_cx}) +
             ($signed({{COORD_W{px[31]}}, px}) <<< sh_amt);
    cy_sum = $signed({{32{view_cy[COORD_W-1]}}, view_cy}) +
             ($signed({{COORD_W{py[31]}}, py}) <<< sh_amt);
  end

  function automatic logic [COORD_W-1:0] sat(input logic signed [EW-1:0] v);
    if (v > CMAX)      return CMAX[COORD_W-1:0];
    else if (v < CMIN) return CMIN[COORD_W-1:0];
    else               return v[COORD_W-1:0];
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      view_cx    <= HOME_CX;
      view_cy    <= '0;
      view_shift <= '0;
    end else if (state == CALC) begin
      case (slot_op)
        OP_HOME: begin
          view_cx    <= HOME_CX;
          view_cy    <= '0;
          view_shift <= '0;
        end
        OP_IN: begin
          view_cx <= sat(cx_sum);
          view_cy <= sat(cy_sum);
          if (view_shift < 5'(MAX_ZOOM)) view_shift <= view_shift + 5'd1;
        end
        OP_OUT: begin
          view_cx <= sat(cx_sum);
          view_cy <= sat(cy_sum);
          if (view_shift != 5'd0) view_shift <= view_shift - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_controller.sv
// Bench for zoom_controller: table of view ops checked at each render handshake, plus directed sequences.
module tb_zoom_controller;

`ifdef ZOOM_WATCHDOG_EN
  localparam int unsigned TO = 100;
`else
  localparam int unsigned TO = 24'hFFFFFF;
`endif
  localparam logic [1:0] HOME = 2'd0, IN = 2'd1, OUT = 2'd2;

  logic        CLK, RESET;
  logic        zoom_in_btn, zoom_out_btn, home_btn;
  logic [25:0] sprite_x, sprite_y;
  logic        render_ready, render_done;
  logic        render_start, busy, timeout_err;
  logic [31:0] view_cx, view_cy;
  logic [4:0]  view_shift;

  zoom_controller #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .zoom_in_btn(zoom_in_btn), .zoom_out_btn(zoom_out_btn), .home_btn(home_btn),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .render_ready(render_ready), .render_done(render_done),
    .render_start(render_start),
    .view_cx(view_cx), .view_cy(view_cy), .view_shift(view_shift),
    .busy(busy), .timeout_err(timeout_err)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [25:0] sx, sy;
    logic [31:0] cx, cy;
    logic [4:0]  sh;
  } vec_t;

  vec_t        tbl[64];
  int          n_vec;
  logic [68:0] exp_q[$];
  int          checks, errors, to_seen;
  logic        hs_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard: every accepted render start is compared against the oldest expected view
  always @(negedge CLK) begin
    if (RESET) begin
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("start_drop", {31'd0, render_start}, 32'd0);
      if (render_start && render_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handshake: got cx=%h cy=%h sh=%0d expected none", view_cx, view_cy, view_shift);
        end else begin
          logic [68:0] e;
          e = exp_q.pop_front();
          chk("view_cx", view_cx, e[68:37]);
          chk("view_cy", view_cy, e[36:5]);
          chk("view_shift", {27'd0, view_shift}, {27'd0, e[4:0]});
        end
        hs_prev = 1'b1;
      end else begin
        hs_prev = 1'b0;
      end
      if (timeout_err) to_seen++;
    end
  end

  // driver tasks
  task automatic add(input logic [1:0] op, input int sx, input int sy,
                     input logic [31:0] cx, input logic [31:0] cy, input int sh);
    tbl[n_vec] = '{op: op, sx: 26'(sx), sy: 26'(sy), cx: cx, cy: cy, sh: 5'(sh)};
    n_vec++;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=1 expected busy=0 within 300 cycles");
    end
  endtask

  task automatic wait_hs();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (render_start && render_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_handshake: got no handshake expected one within 50 cycles");
    end
  endtask

  task automatic press(input logic h, input logic i, input logic o);
    @(posedge CLK); #1;
    home_btn = h; zoom_in_btn = i; zoom_out_btn = o;
    repeat (2) @(posedge CLK);
    #1;
    home_btn = 0; zoom_in_btn = 0; zoom_out_btn = 0;
  endtask

  task automatic done_pulse(input int delay);
    repeat (delay) @(posedge CLK);
    @(posedge CLK); #1 render_done = 1'b1;
    @(posedge CLK); #1 render_done = 1'b0;
  endtask

  task automatic do_op(input vec_t v);
    wait_idle();
    @(posedge CLK); #1;
    sprite_x = v.sx;
    sprite_y = v.sy;
    exp_q.push_back({v.cx, v.cy, v.sh});
    press(v.op == HOME, v.op == IN, v.op == OUT);
    wait_hs();
    done_pulse($urandom_range(0, 4));
  endtask

  initial begin
    checks = 0; errors = 0; to_seen = 0; n_vec = 0; hs_prev = 1'b0;
    RESET = 1'b1;
    home_btn = 0; zoom_in_btn = 0; zoom_out_btn = 0;
    sprite_x = '0; sprite_y = '0;
    render_ready = 1'b0; render_done = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_start", {31'd0, render_start}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_cx", view_cx, 32'hF8000000);
    chk("rst_cy", view_cy, 32'h0);
    chk("rst_shift", {27'd0, view_shift}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);

    // initial frame, renderer stalls for 10 cycles first
    @(posedge CLK); #1;
    RESET = 1'b0;
    exp_q.push_back({32'hF8000000, 32'h0, 5'd0});
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("stall_start", {31'd0, render_start}, 32'd1);
      chk("stall_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge CLK); #1 render_ready = 1'b1;
    wait_hs();
    @(negedge CLK);
    chk("wait_start", {31'd0, render_start}, 32'd0);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    repeat (3) begin
      @(negedge CLK);
      chk("wait_busy_hold", {31'd0, busy}, 32'd1);
    end
    done_pulse(0);
    @(negedge CLK);
    chk("initial_idle", {31'd0, busy}, 32'd0);

    // render_done outside WAIT has no effect
    done_pulse(0);
    repeat (2) begin
      @(negedge CLK);
      chk("stray_done_busy", {31'd0, busy}, 32'd0);
      chk("stray_done_start", {31'd0, render_start}, 32'd0);
    end

    add(IN,    0,  292, 32'hDF800000, 32'h00000000, 1);
    add(IN,  392,  292, 32'hDF800000, 32'h00000000, 2);
    add(OUT, 500,  100, 32'hE1300000, 32'hFD000000, 1);
    add(HOME,  0,    0, 32'hF8000000, 32'h00000000, 0);
    add(OUT, 1000, 1000, 32'h10800000, 32'h12400000, 0);
    add(OUT, 1000, 1000, 32'h29000000, 32'h24800000, 0);
    add(OUT, 1000, 1000, 32'h41800000, 32'h36C00000, 0);
    add(OUT, 1000, 1000, 32'h5A000000, 32'h49000000, 0);
    add(OUT, 1000, 1000, 32'h72800000, 32'h5B400000, 0);
    add(OUT, 1000, 1000, 32'h7FFFFFFF, 32'h6D800000, 0);
    add(OUT, 1000, 1000, 32'h7FFFFFFF, 32'h7FC00000, 0);
    add(OUT, 1000, 1000, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
    add(HOME,  0,    0, 32'hF8000000, 32'h00000000, 0);
    add(OUT,   0,    0, 32'hDF800000, 32'hEDC00000, 0);
    add(OUT,   0,    0, 32'hC7000000, 32'hDB800000, 0);
    add(OUT,   0,    0, 32'hAE800000, 32'hC9400000, 0);
    add(OUT,   0,    0, 32'h96000000, 32'hB7000000, 0);
    add(OUT,   0,    0, 32'h80000000, 32'hA4C00000, 0);
    add(HOME,  0,    0, 32'hF8000000, 32'h00000000, 0);
    for (int k = 1; k <= 16; k++) add(IN, 392, 292, 32'hF8000000, 32'h0, k);
    add(IN,  392,  292, 32'hF8000000, 32'h00000000, 16);
    add(IN,    0,  292, 32'hF7FFE780, 32'h00000000, 16);
    add(OUT, 500,  100, 32'hF7FFEE40, 32'hFFFFF400, 15);

    for (int i = 0; i < n_vec; i++) do_op(tbl[i]);

    // HOME+IN together during WAIT: HOME wins, IN and a later OUT are dropped
    wait_idle();
    @(posedge CLK); #1;
    sprite_x = 392; sprite_y = 292;
    exp_q.push_back({32'hF7FFEE40, 32'hFFFFF400, 5'd14});
    press(0, 0, 1);
    wait_hs();
    @(posedge CLK); #1;
    home_btn = 1; zoom_in_btn = 1;
    @(posedge CLK); #1;
    home_btn = 0; zoom_in_btn = 0;
    repeat (2) @(posedge CLK);
    #1 zoom_out_btn = 1;
    @(posedge CLK); #1 zoom_out_btn = 0;
    exp_q.push_back({32'hF8000000, 32'h0, 5'd0});
    done_pulse(1);
    wait_hs();
    done_pulse(2);
    wait_idle();
    repeat (8) begin
      @(negedge CLK);
      chk("dropped_idle", {31'd0, busy}, 32'd0);
    end

    // reset while waiting for render_done aborts the frame
    @(posedge CLK); #1;
    sprite_x = 0; sprite_y = 292;
    exp_q.push_back({32'hDF800000, 32'h0, 5'd1});
    press(0, 1, 0);
    wait_hs();
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_start", {31'd0, render_start}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd1);
    chk("midrst_cx", view_cx, 32'hF8000000);
    chk("midrst_cy", view_cy, 32'h0);
    chk("midrst_shift", {27'd0, view_shift}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    exp_q.push_back({32'hF8000000, 32'h0, 5'd0});
    wait_hs();
    done_pulse(0);
    wait_idle();

`ifdef ZOOM_WATCHDOG_EN
    // no render_done: the watchdog fires on the 100th WAIT cycle
    begin
      int hit;
      logic busy_at_hit;
      hit = 0;
      busy_at_hit = 1'b0;
      @(posedge CLK); #1;
      sprite_x = 392; sprite_y = 292;
      exp_q.push_back({32'hF8000000, 32'h0, 5'd1});
      press(0, 1, 0);
      wait_hs();
      for (int c = 1; c <= 150; c++) begin
        @(negedge CLK);
        if (timeout_err) begin hit = c; busy_at_hit = busy; break; end
      end
      chk("wd_cycle", 32'(hit), 32'd100);
      chk("wd_busy_at_pulse", {31'd0, busy_at_hit}, 32'd1);
      @(negedge CLK);
      chk("wd_busy_after", {31'd0, busy}, 32'd0);
      chk("wd_pulse_width", {31'd0, timeout_err}, 32'd0);
      chk("wd_pulse_count", 32'(to_seen), 32'd1);
    end
`else
    chk("timeout_tied_low", 32'(to_seen), 32'd0);
`endif

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1, "bench time limit reached");
  end

endmodule
